// File: rtl/alu_serdes_if.sv
// Operand/result handshake bundle plus the serial ALU-side port group.
// The master side is the bus/ALU environment; the slave side is the serdes.
interface alu_serdes_if #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
);
    localparam int OPW = 2 * REG_BITS;

    logic              load_valid;
    logic              load_ready;
    logic [OPW-1:0]    load_data;
    logic              load_pair;
    logic              alu_op_valid;
    logic              alu_op_done;
    logic [NSHIFT-1:0] alu_data_in;
    logic [NSHIFT-1:0] alu_data_out;
    logic              result_valid;
    logic              result_ready;
    logic [OPW-1:0]    result_data;
    logic              sync_error;

    modport master (
        output load_valid, load_data, load_pair, alu_op_done, alu_data_out, result_ready,
        input  load_ready, alu_op_valid, alu_data_in, result_valid, result_data, sync_error
    );

    modport slave (
        input  load_valid, load_data, load_pair, alu_op_done, alu_data_out, result_ready,
        output load_ready, alu_op_valid, alu_data_in, result_valid, result_data, sync_error
    );
endinterface

// File: rtl/alu_serdes.sv
// Feeds a byte or register-pair operand to the serial ALU one chunk per
// cycle (LSB chunk first) and collects the returned chunks into a
// parallel result offered on a valid/ready port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | idle, accepting an operand
// S_RUN   | ALU op_valid held; shifting src out and data_out into cap
// S_DONE  | result presented until the consumer takes it
module alu_serdes #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input logic          clk,
    input logic          reset,
    alu_serdes_if.slave  bus
);
    localparam int OPW      = 2 * REG_BITS;
    localparam int NCHUNK   = OPW / NSHIFT;
    localparam int CNT_BITS = $clog2(NCHUNK);
    // Count value on the cycle the ALU should raise op_done.
    localparam logic [CNT_BITS-1:0] DONE_PAIR = CNT_BITS'(NCHUNK - 1);
    localparam logic [CNT_BITS-1:0] DONE_BYTE = CNT_BITS'(REG_BITS / NSHIFT - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OPW-1:0]      src_q;
    logic [OPW-1:0]      cap_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                pair_q;
    logic                sync_err_q;

    logic                load_ready_w;
    logic                load_hs_w;
    logic [OPW-1:0]      result_w;
    logic [NSHIFT-1:0]   data_in_w;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: op_done alone ends RUN; DONE may hand straight over to a new RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: if (bus.load_valid)   state_d = S_RUN;
            S_RUN:   if (bus.alu_op_done)  state_d = S_DONE;
            S_DONE:  if (bus.result_ready) state_d = bus.load_valid ? S_RUN : S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    // Outputs decoded from state and registers; a byte result is right-aligned.
    always_comb begin
        load_ready_w = (state_q == S_EMPTY) || ((state_q == S_DONE) && bus.result_ready);
        data_in_w    = '0;
        result_w     = '0;
        if (state_q == S_RUN) begin
            data_in_w = src_q[NSHIFT-1:0];
        end
        if (state_q == S_DONE) begin
            result_w = pair_q ? cap_q : {{REG_BITS{1'b0}}, cap_q[OPW-1:REG_BITS]};
        end
    end

    assign load_hs_w        = bus.load_valid && load_ready_w;
    assign bus.load_ready   = load_ready_w;
    assign bus.alu_op_valid = (state_q == S_RUN);
    assign bus.alu_data_in  = data_in_w;
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result_data  = result_w;
    assign bus.sync_error   = sync_err_q;

    // Datapath: load operand, then shift out src and shift in ALU chunks each RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q      <= '0;
            cap_q      <= '0;
            cnt_q      <= '0;
            pair_q     <= 1'b0;
            sync_err_q <= 1'b0;
        end else if (load_hs_w) begin
            src_q  <= bus.load_pair ? bus.load_data
                                    : {{REG_BITS{1'b0}}, bus.load_data[REG_BITS-1:0]};
            pair_q <= bus.load_pair;
            cnt_q  <= '0;
            cap_q  <= '0;
        end else if (state_q == S_RUN) begin
            src_q <= src_q >> NSHIFT;
            cap_q <= {bus.alu_data_out, cap_q[OPW-1:NSHIFT]};
            cnt_q <= cnt_q + CNT_BITS'(1);
            if (bus.alu_op_done && (cnt_q != (pair_q ? DONE_PAIR : DONE_BYTE))) begin
                sync_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_serdes.sv
module tb_alu_serdes;
    localparam int RB  = 8;
    localparam int NS  = 2;
    localparam int OPW = 2 * RB;

    typedef struct {
        logic [OPW-1:0] res;
        bit             sync;
        int             vcyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_serdes_if #(.REG_BITS(RB), .NSHIFT(NS)) bus ();

    alu_serdes #(.REG_BITS(RB), .NSHIFT(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t       exp_q[$];
    logic [1:0] chunk_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  cyc      = 0;
    int  run_cnt  = 0;
    int  done_at  = 7;
    bit  spur     = 1'b0;
    bit  exp_sync = 1'b0;
    bit  rnd_rr   = 1'b0;
    bit  rv_prev  = 1'b0;

    // Loopback ALU: echoes data_in, raises op_done on the chosen active cycle.
    assign bus.alu_data_out = bus.alu_data_in;
    assign bus.alu_op_done  = (bus.alu_op_valid && (run_cnt == done_at)) || spur;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        run_cnt <= bus.alu_op_valid ? run_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: checks chunks while running and the result while presented.
    always @(negedge clk) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            if (bus.alu_op_valid) begin
                if (chunk_q.size() == 0) fail("unexpected_run");
                else chk("chunk", 32'(bus.alu_data_in), 32'(chunk_q.pop_front()));
            end else begin
                chk("idle_data_in", 32'(bus.alu_data_in), 32'd0);
            end
            if (bus.result_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    if (!rv_prev) chk("latency", cyc, exp_q[0].vcyc);
                    chk("result_data", 32'(bus.result_data), 32'(exp_q[0].res));
                    chk("sync_error", 32'(bus.sync_error), 32'(exp_q[0].sync));
                    chk("load_ready_done", 32'(bus.load_ready), 32'(bus.result_ready));
                    if (bus.result_ready) void'(exp_q.pop_front());
                end
            end
            rv_prev = bus.result_valid;
        end
    end

    // Offer one operand; dn is the cnt value on which the ALU raises op_done.
    task automatic send(input logic [OPW-1:0] d, input bit p, input int dn);
        int g;
        int n;
        logic [OPW-1:0] src;
        logic [31:0] v;
        logic [31:0] capw;
        logic [OPW-1:0] res;
        bit ok;
        g = 0;
        while (bus.alu_op_valid && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        done_at       = dn;
        bus.load_data = d;
        bus.load_pair = p;
        bus.load_valid = 1'b1;
        ok = 1'b0;
        g  = 0;
        while (!ok && g < 200) begin
            @(negedge clk);
            if (bus.load_ready) ok = 1'b1;
            g++;
        end
        if (!ok) begin
            fail("load_timeout");
        end else begin
            src = p ? d : {8'h00, d[RB-1:0]};
            n   = dn + 1;
            v   = 0;
            for (int k = 0; k < n; k++) begin
                logic [1:0] c;
                c = 2'((src >> (2 * k)) & 16'h3);
                chunk_q.push_back(c);
                v = v | (32'(c) << (2 * k));
            end
            capw = v << (OPW - 2 * n);
            res  = p ? capw[OPW-1:0] : {8'h00, capw[OPW-1:RB]};
            if (dn != (p ? 7 : 3)) exp_sync = 1'b1;
            exp_q.push_back('{res: res, sync: exp_sync, vcyc: cyc + n + 1});
        end
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rr) bus.result_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        bus.load_valid   = 1'b0;
        bus.load_data    = '0;
        bus.load_pair    = 1'b0;
        bus.result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_op_valid", 32'(bus.alu_op_valid), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result_data", 32'(bus.result_data), 32'd0);
        chk("rst_sync_error", 32'(bus.sync_error), 32'd0);
        @(posedge clk); #1;

        send(16'h1234, 1'b1, 7);
        drain();
        send(16'hFFA5, 1'b0, 3);
        drain();

        // Backpressure with spurious op_done while DONE.
        bus.result_ready = 1'b0;
        send(16'hC3E1, 1'b1, 7);
        begin
            int g;
            g = 0;
            while (!bus.result_valid && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (!bus.result_valid) fail("bp_no_result");
        end
        spur = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_still_valid", 32'(bus.result_valid), 32'd1);
        chk("bp_sync_after_spur", 32'(bus.sync_error), 32'd0);
        spur = 1'b0;
        bus.result_ready = 1'b1;
        send(16'h00FF, 1'b1, 7);
        drain();

        // Spurious op_done while EMPTY.
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_result_valid", 32'(bus.result_valid), 32'd0);
            chk("spur_op_valid", 32'(bus.alu_op_valid), 32'd0);
            chk("spur_sync_error", 32'(bus.sync_error), 32'd0);
        end
        @(posedge clk); #1;
        spur = 1'b0;

        // Early done sets the sticky error, which survives a correct op.
        send(16'h1234, 1'b1, 2);
        drain();
        send(16'h0F0F, 1'b1, 7);
        drain();

        // Reset in the 4th RUN cycle.
        send(16'h5A5A, 1'b1, 7);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        chunk_q.delete();
        exp_q.delete();
        exp_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstrun_op_valid", 32'(bus.alu_op_valid), 32'd0);
        chk("rstrun_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rstrun_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rstrun_sync_error", 32'(bus.sync_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(16'h003C, 1'b0, 3);
        drain();

        // Randomized operations with random consumer backpressure.
        rnd_rr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [OPW-1:0] d;
            bit p;
            int dn;
            d  = 16'($urandom);
            p  = 1'($urandom_range(0, 1));
            dn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : (p ? 7 : 3);
            send(d, p, dn);
        end
        drain();
        rnd_rr = 1'b0;
        bus.result_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_serdes.md
# alu_serdes

Parallel-to-serial operand feeder and serial-to-parallel result collector for the 2-bit-per-cycle ALU. It accepts a byte or register-pair operand from the memory/instruction side and drives it onto the ALU external data input one NSHIFT-bit chunk per cycle, LSB chunk first, while the ALU's op_valid is held. In the same cycles it collects the ALU's data_out chunks into a parallel result, which it presents on a valid/ready interface. It sits between the bus interface and the ALU's data_in1/data_in2/data_out ports.

## Interface
- REG_BITS, 8: bits per register; must equal the ALU's REG_BITS.
- NSHIFT, 2: bits per serial chunk; must equal the ALU's NSHIFT.
- Derived: OPW = 2*REG_BITS; CNT_BITS = clog2(OPW/NSHIFT).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  operand offered.
- load_ready  out  1  operand accepted when high together with load_valid.
- load_data  in  OPW  operand; single-byte mode uses [REG_BITS-1:0] and ignores the upper bits.
- load_pair  in  1  1 = 16-bit pair operation, 0 = single byte; sampled on load handshake.
- alu_op_valid  out  1  drives ALU op_valid; high only in RUN.
- alu_op_done  in  1  ALU op_done.
- alu_data_in  out  NSHIFT  drives ALU data_in1 and/or data_in2.
- alu_data_out  in  NSHIFT  ALU data_out; ALU must be configured with output_scan_out=0.
- result_valid  out  1  high in DONE.
- result_ready  in  1  consumer accepts the result.
- result_data  out  OPW  collected result.
- sync_error  out  1  sticky; set when op_done timing mismatches the expected count.

## Operation
- Registers: state (EMPTY, RUN, DONE); src shift register (OPW); cap shift register (OPW); pair flag; counter (CNT_BITS).
- EMPTY:
  - load_ready=1.
  - On handshake: src<=load_data (upper byte zeroed if !load_pair); pair<=load_pair; cnt<=0; cap<=0; next state RUN.
- RUN, every cycle:
  - alu_op_valid=1.
  - alu_data_in=src[NSHIFT-1:0].
  - At the edge: src<=src>>NSHIFT; cap<={alu_data_out, cap[OPW-1:NSHIFT]}; cnt<=cnt+1.
- RUN exit:
  - alu_op_done=1 moves to DONE at that edge; that cycle's chunk is still captured.
  - Expected done count is 7 for pair, 3 for byte (NSHIFT=2, REG_BITS=8). If alu_op_done arrives at any other cnt value, sync_error<=1.
  - alu_op_done is authoritative; RUN never exits without it.
- Outside RUN:
  - alu_data_in=0.
  - alu_op_done is ignored and never sets sync_error.
- DONE:
  - result_valid=1.
  - result_data = pair ? cap : {zeros, cap[OPW-1:REG_BITS]}, which right-aligns the byte result.
  - cap holds its value until handshake.
- Result handshake in DONE:
  - result_valid && result_ready: next state EMPTY, unless load_valid is also high.
  - load_ready = (state==EMPTY) || (state==DONE && result_ready). A same-cycle result release and new load go directly DONE->RUN with the new operand.
- Outputs are combinational from state and registers only; there is no load->data_in combinational path.

## Timing
- Reset values:
  - state=EMPTY, src=0, cap=0, cnt=0, pair=0, sync_error=0.
  - Therefore load_ready=1, alu_op_valid=0, alu_data_in=0, result_valid=0, result_data=0.
- Reset during RUN: alu_op_valid=0 from the next cycle. The partial result is discarded and sync_error is cleared. Only reset clears sync_error.
- Latency, load handshake at edge E:
  - RUN covers cycles E+1..E+8 for pair, E+1..E+4 for byte.
  - result_valid is high in cycle E+9 (pair) or E+5 (byte).
- Back-to-back with result_ready held high: one operand per 9 (pair) or 5 (byte) cycles.
- Backpressure: while result_ready=0, DONE holds indefinitely with result_data stable and load_ready=0.

## Test plan
- Pair load 0x1234, loopback ALU model (data_out=data_in, op_done at 8th active cycle) -> alu_data_in sequence 00,01,11,00,10,00,01,00; result_data=0x1234 in cycle E+9; sync_error=0.
- Byte load 0xA5 (load_data=0xFFA5) -> chunks 01,01,10,10; src upper byte zeroed; result_data=0x00A5 in cycle E+5.
- Backpressure: result_ready=0 for 5 cycles after DONE -> result_valid and result_data stable, load_ready=0. Then raise result_ready with load_valid=1 (0x00FF, pair) -> same-edge release, RUN starts the next cycle, first chunk 11.
- Early done: pair load with op_done asserted at cnt=2 -> DONE next cycle, sync_error=1 and stays 1 through subsequent correct operations until reset.
- Reset asserted at the 4th RUN cycle -> next cycle alu_op_valid=0, load_ready=1, result_valid=0, sync_error=0. A following byte load 0x3C completes normally with result 0x003C.
- Spurious alu_op_done=1 while EMPTY or DONE -> no state change and sync_error stays 0.
